evm_session_ctrl: RTL and testbench

Clocked sequencer for one voting booth session. It verifies the voter ID against a voted-bitmap, waits for officer authorisation, accepts one ballot and commits it to per-candidate tallies. Timeouts and poll-closure abort a session cleanly. It sits between the booth button/ID front end (debounced, synchronised pulses) and the result display/readout logic.

---
 rtl/evm_session_ctrl.sv | 124 ++++++++++++
 tb/tb_evm_session_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/evm_session_ctrl.sv
// Voting-booth session sequencer: ID check against voted bitmap, officer auth, one ballot, commit to tallies.
// check/auth/vote each advance state one edge later; commit lands one edge after vote; no backpressure, inputs are pulses.
module evm_session_ctrl #(
   parameter int VOTERS  = 32,
   parameter int CANDS   = 4,
   parameter int TALLY_W = 8,
   parameter int TIMEOUT = 1000,
   localparam int SW = $clog2(VOTERS),
   localparam int CW = $clog2(CANDS)
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               poll_open,
   input  logic [SW-1:0]      serial,
   input  logic               check,
   input  logic               auth,
   input  logic               vote_valid,
   input  logic [CW-1:0]      cand,
   input  logic [CW-1:0]      rd_cand,
   output logic [TALLY_W-1:0] rd_tally,
   output logic               red_led,
   output logic               green_led,
   output logic               busy,
   output logic               reject,
   output logic               timeout,
   output logic               vote_done,
   output logic [SW:0]        voters_done
);

   localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [TW-1:0]      TMAX    = TW'(TIMEOUT - 1);
   localparam logic [TW-1:0]      T_ONE   = TW'(1);
   localparam logic [SW:0]        V_ONE   = (SW + 1)'(1);
   localparam logic [TALLY_W-1:0] C_ONE   = TALLY_W'(1);
   localparam logic [SW:0]        VOTERS_L = VOTERS[SW:0];
   localparam logic [CW:0]        CANDS_L  = CANDS[CW:0];

   typedef enum logic [1:0] {IDLE, VERIFIED, BALLOT, COMMIT} state_t;

   state_t              state, state_nxt;
   logic [TW-1:0]       timer;
   logic [SW-1:0]       cur_id;
   logic [CW-1:0]       cand_lat;
   logic [VOTERS-1:0]   voted;
   logic [TALLY_W-1:0]  tally [CANDS];
   logic                serial_ok, cand_ok, expired;
   logic                reject_nxt, timeout_nxt, vote_done_nxt;

   assign serial_ok = ({1'b0, serial} < VOTERS_L);
   assign cand_ok   = ({1'b0, cand} < CANDS_L);
   assign expired   = (timer == TMAX);

   // Abort by poll close outranks any advancing event; an advancing event outranks timer expiry.
   always_comb begin
      state_nxt     = state;
      reject_nxt    = 1'b0;
      timeout_nxt   = 1'b0;
      vote_done_nxt = 1'b0;
      case (state)
         IDLE: begin
            if (check) begin
               if (poll_open && serial_ok && !voted[serial]) state_nxt = VERIFIED;
               else                                          reject_nxt = 1'b1;
            end
         end
         VERIFIED: begin
            if (!poll_open)   begin state_nxt = IDLE; timeout_nxt = 1'b1; end
            else if (auth)          state_nxt = BALLOT;
            else if (expired) begin state_nxt = IDLE; timeout_nxt = 1'b1; end
         end
         BALLOT: begin
            if (!poll_open)                  begin state_nxt = IDLE; timeout_nxt = 1'b1; end
            else if (vote_valid && cand_ok)        state_nxt = COMMIT;
            else if (expired)                begin state_nxt = IDLE; timeout_nxt = 1'b1; end
         end
         COMMIT: begin
            state_nxt     = IDLE;
            vote_done_nxt = 1'b1;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         timer       <= '0;
         cur_id      <= '0;
         cand_lat    <= '0;
         voted       <= '0;
         voters_done <= '0;
         red_led     <= 1'b1;
         green_led   <= 1'b1;
         busy        <= 1'b0;
         reject      <= 1'b0;
         timeout     <= 1'b0;
         vote_done   <= 1'b0;
         for (int i = 0; i < CANDS; i++) tally[i] <= '0;
      end else begin
         state     <= state_nxt;
         reject    <= reject_nxt;
         timeout   <= timeout_nxt;
         vote_done <= vote_done_nxt;
         red_led   <= (state_nxt != VERIFIED);
         green_led <= (state_nxt != BALLOT);
         busy      <= (state_nxt != IDLE);
         if (state_nxt != state)                        timer <= '0;
         else if (state == VERIFIED || state == BALLOT) timer <= timer + T_ONE;
         if (state == IDLE && state_nxt == VERIFIED)    cur_id <= serial;
         if (state == BALLOT && state_nxt == COMMIT)    cand_lat <= cand;
         if (state == COMMIT) begin
            voted[cur_id] <= 1'b1;
            voters_done   <= voters_done + V_ONE;
            if (tally[cand_lat] != '1) tally[cand_lat] <= tally[cand_lat] + C_ONE;
         end
      end
   end

   always_comb begin
      rd_tally = '0;
      if ({1'b0, rd_cand} < CANDS_L) rd_tally = tally[rd_cand];
   end

endmodule

// File: tb/tb_evm_session_ctrl.sv
// Directed bench for evm_session_ctrl with a non-power-of-two voter count, 3 candidates, 2-bit tallies, TIMEOUT=8.
module tb_evm_session_ctrl;
   localparam int VOTERS = 20, CANDS = 3, TALLY_W = 2, TIMEOUT = 8;
   localparam int SW = $clog2(VOTERS), CW = $clog2(CANDS);

   logic clk = 1'b0, reset_n = 1'b0, poll_open = 1'b0;
   logic [SW-1:0] serial = '0;
   logic check = 1'b0, auth = 1'b0, vote_valid = 1'b0;
   logic [CW-1:0] cand = '0, rd_cand = '0;
   logic [TALLY_W-1:0] rd_tally;
   logic red_led, green_led, busy, reject, timeout, vote_done;
   logic [SW:0] voters_done;

   int total = 0, bad = 0;

   evm_session_ctrl #(.VOTERS(VOTERS), .CANDS(CANDS), .TALLY_W(TALLY_W), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset_n(reset_n), .poll_open(poll_open), .serial(serial), .check(check),
      .auth(auth), .vote_valid(vote_valid), .cand(cand), .rd_cand(rd_cand), .rd_tally(rd_tally),
      .red_led(red_led), .green_led(green_led), .busy(busy), .reject(reject), .timeout(timeout),
      .vote_done(vote_done), .voters_done(voters_done)
   );

   always #5 clk = ~clk;

   // Inputs change 1 time unit after a rising edge; outputs are observed at the same point.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_check(input int id);
      serial = SW'(id); check = 1'b1; tick(); check = 1'b0;
   endtask

   task automatic pulse_auth();
      auth = 1'b1; tick(); auth = 1'b0;
   endtask

   task automatic pulse_vote(input int c);
      cand = CW'(c); vote_valid = 1'b1; tick(); vote_valid = 1'b0;
   endtask

   task automatic test_reset();
      repeat (3) tick();
      total++; if (red_led !== 1'b1)   begin bad++; $display("FAIL reset_red got=%b want=1", red_led); end
      total++; if (green_led !== 1'b1) begin bad++; $display("FAIL reset_green got=%b want=1", green_led); end
      total++; if ({busy, reject, timeout, vote_done} !== 4'b0000)
         begin bad++; $display("FAIL reset_pulses got=%b want=0000", {busy, reject, timeout, vote_done}); end
      total++; if (voters_done !== 6'd0) begin bad++; $display("FAIL reset_voters got=%0d want=0", voters_done); end
      for (int i = 0; i < CANDS; i++) begin
         rd_cand = CW'(i); #1;
         total++; if (rd_tally !== 2'd0) begin bad++; $display("FAIL reset_tally%0d got=%0d want=0", i, rd_tally); end
      end
      reset_n = 1'b1;
      tick();
   endtask

   task automatic test_happy();
      poll_open = 1'b1;
      pulse_check(5);
      total++; if ({red_led, green_led, busy} !== 3'b011)
         begin bad++; $display("FAIL happy_verified got=%b want=011", {red_led, green_led, busy}); end
      tick(); tick();
      pulse_auth();
      total++; if ({red_led, green_led, busy} !== 3'b101)
         begin bad++; $display("FAIL happy_ballot got=%b want=101", {red_led, green_led, busy}); end
      pulse_vote(2);
      total++; if ({red_led, green_led, busy, vote_done} !== 4'b1110)
         begin bad++; $display("FAIL happy_commit got=%b want=1110", {red_led, green_led, busy, vote_done}); end
      tick();
      total++; if ({busy, vote_done} !== 2'b01)
         begin bad++; $display("FAIL happy_done got=%b want=01", {busy, vote_done}); end
      total++; if (voters_done !== 6'd1) begin bad++; $display("FAIL happy_voters got=%0d want=1", voters_done); end
      rd_cand = 2'd2; #1;
      total++; if (rd_tally !== 2'd1) begin bad++; $display("FAIL happy_tally2 got=%0d want=1", rd_tally); end
      tick();
      total++; if (vote_done !== 1'b0) begin bad++; $display("FAIL happy_done_pulse got=%b want=0", vote_done); end
   endtask

   task automatic test_double_vote();
      pulse_check(5);
      total++; if ({reject, busy, red_led, green_led} !== 4'b1011)
         begin bad++; $display("FAIL dbl_reject got=%b want=1011", {reject, busy, red_led, green_led}); end
      tick();
      total++; if (reject !== 1'b0) begin bad++; $display("FAIL dbl_reject_pulse got=%b want=0", reject); end
      rd_cand = 2'd2; #1;
      total++; if (rd_tally !== 2'd1) begin bad++; $display("FAIL dbl_tally2 got=%0d want=1", rd_tally); end
   endtask

   task automatic test_timeout();
      logic early;
      pulse_check(3);
      early = 1'b0;
      for (int k = 1; k < TIMEOUT; k++) begin
         tick();
         if (timeout !== 1'b0 || red_led !== 1'b0) early = 1'b1;
      end
      total++; if (early !== 1'b0) begin bad++; $display("FAIL to_early got=%b want=0", early); end
      tick();
      total++; if ({timeout, red_led, green_led, busy} !== 4'b1110)
         begin bad++; $display("FAIL to_abort got=%b want=1110", {timeout, red_led, green_led, busy}); end
      tick();
      pulse_check(3);
      total++; if ({reject, red_led} !== 2'b00)
         begin bad++; $display("FAIL to_recheck got=%b want=00", {reject, red_led}); end
      poll_open = 1'b0;
      tick();
      total++; if ({timeout, red_led, busy} !== 3'b110)
         begin bad++; $display("FAIL to_poll_verified got=%b want=110", {timeout, red_led, busy}); end
      poll_open = 1'b1;
      tick();
   endtask

   task automatic test_invalid_cand();
      logic early;
      pulse_check(7);
      pulse_auth();
      pulse_vote(3);
      total++; if ({green_led, busy} !== 2'b01)
         begin bad++; $display("FAIL inv_cand_stay got=%b want=01", {green_led, busy}); end
      early = 1'b0;
      for (int k = 2; k < TIMEOUT; k++) begin
         tick();
         if (timeout !== 1'b0 || vote_done !== 1'b0 || green_led !== 1'b0) early = 1'b1;
      end
      total++; if (early !== 1'b0) begin bad++; $display("FAIL inv_cand_hold got=%b want=0", early); end
      tick();
      total++; if ({timeout, green_led} !== 2'b11)
         begin bad++; $display("FAIL inv_cand_expiry got=%b want=11", {timeout, green_led}); end
      tick();
   endtask

   task automatic test_race();
      pulse_check(9);
      repeat (TIMEOUT - 1) tick();
      pulse_auth();
      total++; if ({timeout, green_led, busy} !== 3'b001)
         begin bad++; $display("FAIL race_event_wins got=%b want=001", {timeout, green_led, busy}); end
      poll_open = 1'b0;
      pulse_vote(0);
      total++; if ({timeout, green_led, busy} !== 3'b110)
         begin bad++; $display("FAIL race_abort_wins got=%b want=110", {timeout, green_led, busy}); end
      tick();
      total++; if ({vote_done, voters_done} !== {1'b0, 6'd1})
         begin bad++; $display("FAIL race_no_commit got=%b/%0d want=0/1", vote_done, voters_done); end
      rd_cand = 2'd0; #1;
      total++; if (rd_tally !== 2'd0) begin bad++; $display("FAIL race_tally0 got=%0d want=0", rd_tally); end
   endtask

   task automatic test_rejects();
      poll_open = 1'b0;
      pulse_check(8);
      total++; if ({reject, busy} !== 2'b10) begin bad++; $display("FAIL rej_poll got=%b want=10", {reject, busy}); end
      poll_open = 1'b1;
      tick();
      pulse_check(20);
      total++; if ({reject, busy} !== 2'b10) begin bad++; $display("FAIL rej_range20 got=%b want=10", {reject, busy}); end
      tick();
      pulse_check(31);
      total++; if ({reject, busy} !== 2'b10) begin bad++; $display("FAIL rej_range31 got=%b want=10", {reject, busy}); end
      tick();
   endtask

   task automatic test_back_to_back();
      logic [TALLY_W-1:0] exp_t [4];
      exp_t[0] = 2'd0; exp_t[1] = 2'd3; exp_t[2] = 2'd1; exp_t[3] = 2'd0;
      for (int id = 10; id < 14; id++) begin
         pulse_check(id);
         pulse_auth();
         pulse_vote(1);
         tick();
         total++; if (vote_done !== 1'b1) begin bad++; $display("FAIL b2b_done id=%0d got=%b want=1", id, vote_done); end
      end
      total++; if (voters_done !== 6'd5) begin bad++; $display("FAIL b2b_voters got=%0d want=5", voters_done); end
      for (int i = 0; i < 4; i++) begin
         rd_cand = CW'(i); #1;
         total++; if (rd_tally !== exp_t[i])
            begin bad++; $display("FAIL sweep_rd%0d got=%0d want=%0d", i, rd_tally, exp_t[i]); end
      end
   endtask

   task automatic test_reset_mid();
      tick();
      pulse_check(14);
      pulse_auth();
      #2 reset_n = 1'b0;
      #1;
      total++; if ({red_led, green_led, busy} !== 3'b110)
         begin bad++; $display("FAIL arst_outputs got=%b want=110", {red_led, green_led, busy}); end
      total++; if (voters_done !== 6'd0) begin bad++; $display("FAIL arst_voters got=%0d want=0", voters_done); end
      rd_cand = 2'd1; #1;
      total++; if (rd_tally !== 2'd0) begin bad++; $display("FAIL arst_tally1 got=%0d want=0", rd_tally); end
      tick();
      reset_n = 1'b1;
      tick();
      pulse_check(5);
      total++; if ({reject, red_led} !== 2'b00)
         begin bad++; $display("FAIL arst_bitmap got=%b want=00", {reject, red_led}); end
   endtask

   initial begin
      test_reset();
      test_happy();
      test_double_vote();
      test_timeout();
      test_invalid_cand();
      test_race();
      test_rejects();
      test_back_to_back();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
